// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: weighted round-robin arbiter, valid/ready grant, epoch or continuous service; ports clk, reset, request, weight, grant_ready in; grant_valid, grant_id, grant_onehot, grant_last, stall out
module weighted_rr_arbiter #(
  parameter int N = 8,
  parameter int WW = 4,
  parameter int EPOCH_MODE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           request,
  input  logic [N*WW-1:0]        weight,
  output logic                   grant_valid,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic [N-1:0]           grant_onehot,
  input  logic                   grant_ready,
  output logic                   grant_last,
  output logic                   stall
);
  localparam int IW = $clog2(N);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, win;
  logic [WW-1:0] credit_q, credit_d, w;
  logic [N-1:0] pend_q, pend_d, oh_q, oh_d, qual;
  logic stall_q, stall_d;
  assign grant_valid = state_q == GRANT;
  assign grant_id = id_q;
  assign grant_onehot = oh_q;
  assign stall = stall_q;
  assign grant_last = grant_valid & ((credit_q == WW'(1)) | ~request[id_q]);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    credit_d = credit_q;
    pend_d = pend_q;
    oh_d = oh_q;
    qual = (EPOCH_MODE != 0 && pend_q != '0) ? pend_q & request : request;
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      win = qual[(int'(ptr_q) + k) % N] ? IW'((int'(ptr_q) + k) % N) : win;
    w = weight[int'(win)*WW +: WW];
    if (state_q == IDLE) begin
      if (EPOCH_MODE != 0) pend_d = qual;
      if (qual != '0) begin
        state_d = GRANT;
        id_d = win;
        oh_d = N'(1) << win;
        credit_d = w == '0 ? WW'(1) : w;
      end
    end else if (grant_ready) begin
      if (grant_last) begin
        state_d = IDLE;
        oh_d = '0;
        ptr_d = id_q == IW'(N - 1) ? '0 : id_q + 1'b1;
        if (EPOCH_MODE != 0) pend_d[id_q] = 1'b0;
      end else begin
        credit_d = credit_q - 1'b1;
      end
    end
    stall_d = EPOCH_MODE != 0 && pend_d != '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      credit_q <= '0;
      pend_q <= '0;
      oh_q <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      credit_q <= credit_d;
      pend_q <= pend_d;
      oh_q <= oh_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb_weighted_rr_arbiter: checks an 8-way epoch arbiter and a 5-way continuous arbiter against a behavioural model
module tb_weighted_rr_arbiter;
  logic clk = 0, reset, ready;
  logic [7:0] r8;
  logic [31:0] w8;
  logic [4:0] r5;
  logic [19:0] w5;
  logic gv0, gl0, st0, gv1, gl1, st1;
  logic [2:0] gid0, gid1;
  logic [7:0] goh0;
  logic [4:0] goh1;
  int checks = 0, errors = 0;
  bit armed = 0;
  int busy[2], holder[2], left[2], ptr[2], pend[2];
  int nn[2] = '{8, 5};
  int ep[2] = '{1, 0};
  int log0[$], log1[$];

  weighted_rr_arbiter #(.N(8), .WW(4), .EPOCH_MODE(1)) u8 (
    .clk(clk), .reset(reset), .request(r8), .weight(w8), .grant_valid(gv0), .grant_id(gid0),
    .grant_onehot(goh0), .grant_ready(ready), .grant_last(gl0), .stall(st0));
  weighted_rr_arbiter #(.N(5), .WW(4), .EPOCH_MODE(0)) u5 (
    .clk(clk), .reset(reset), .request(r5), .weight(w5), .grant_valid(gv1), .grant_id(gid1),
    .grant_onehot(goh1), .grant_ready(ready), .grant_last(gl1), .stall(st1));

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int req_of(int i);
    return i == 0 ? int'(r8) : int'(r5);
  endfunction

  function automatic int wt(int i, int j);
    return i == 0 ? int'(w8[j*4 +: 4]) : int'(w5[j*4 +: 4]);
  endfunction

  function automatic int mlast(int i);
    return (busy[i] != 0 && (left[i] == 1 || ((req_of(i) >> holder[i]) & 1) == 0)) ? 1 : 0;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int rq, set, found;
      rq = req_of(i);
      if (reset) begin
        busy[i] = 0; holder[i] = 0; left[i] = 0; ptr[i] = 0; pend[i] = 0;
      end else if (busy[i] == 0) begin
        set = (ep[i] != 0 && pend[i] != 0) ? (pend[i] & rq) : rq;
        if (ep[i] != 0) pend[i] = set;
        found = 0;
        for (int k = 0; k < nn[i]; k++) begin
          int j;
          j = (ptr[i] + k) % nn[i];
          if (found == 0 && ((set >> j) & 1) != 0) begin
            found = 1;
            holder[i] = j;
          end
        end
        if (found != 0) begin
          busy[i] = 1;
          left[i] = wt(i, holder[i]) == 0 ? 1 : wt(i, holder[i]);
        end
      end else if (ready) begin
        if (mlast(i) != 0) begin
          busy[i] = 0;
          ptr[i] = (holder[i] + 1) % nn[i];
          pend[i] = pend[i] & ~(1 << holder[i]);
        end else begin
          left[i] = left[i] - 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        int v, id, oh, l, s;
        v = i == 0 ? int'(gv0) : int'(gv1);
        id = i == 0 ? int'(gid0) : int'(gid1);
        oh = i == 0 ? int'(goh0) : int'(goh1);
        l = i == 0 ? int'(gl0) : int'(gl1);
        s = i == 0 ? int'(st0) : int'(st1);
        chk($sformatf("valid%0d", i), v, busy[i]);
        if (busy[i] != 0) chk($sformatf("id%0d", i), id, holder[i]);
        chk($sformatf("onehot%0d", i), oh, busy[i] != 0 ? (1 << holder[i]) : 0);
        chk($sformatf("last%0d", i), l, mlast(i));
        chk($sformatf("stall%0d", i), s, (ep[i] != 0 && pend[i] != 0) ? 1 : 0);
        if (v != 0 && ready) begin
          if (i == 0) log0.push_back(id * 2 + l);
          else log1.push_back(id * 2 + l);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(1);
    reset = 0;
    log0.delete();
    log1.delete();
  endtask

  task automatic check_log(string nm, int q[$], int e[$]);
    for (int k = 0; k < e.size(); k++)
      chk($sformatf("%s[%0d]", nm, k), k < q.size() ? q[k] : -1, e[k]);
  endtask

  initial begin
    reset = 1; r8 = 0; r5 = 0; w8 = 0; w5 = 0; ready = 0;
    cyc(1);
    armed = 1;
    cyc(1);
    @(negedge clk);
    chk("rst_valid", int'(gv0), 0);
    chk("rst_id", int'(gid0), 0);
    chk("rst_onehot", int'(goh0), 0);
    chk("rst_last", int'(gl0), 0);
    chk("rst_stall", int'(st0), 0);
    @(posedge clk); #1;
    reset = 0;
    // single requester, weight 3
    do_reset();
    w8 = 32'h0000_0300; r8 = 8'h04; ready = 1;
    cyc(9);
    r8 = 0;
    cyc(4);
    check_log("w3", log0, '{4, 4, 5, 4, 4, 5});
    // wrap-around on both instances
    do_reset();
    w8 = 32'h1111_1111; w5 = 20'h11111; r8 = 8'h81; r5 = 5'h11;
    cyc(9);
    r8 = 0; r5 = 0;
    cyc(3);
    check_log("wrap8", log0, '{1, 15, 1, 15});
    check_log("wrap5", log1, '{1, 9, 1, 9});
    // epoch admission
    do_reset();
    r8 = 8'h06;
    cyc(1);
    r8 = 8'h07;
    @(negedge clk);
    chk("ep_stall1", int'(st0), 1);
    chk("ep_id1", int'(gid0), 1);
    @(posedge clk); #1;
    cyc(1);
    @(negedge clk);
    chk("ep_stall2", int'(st0), 1);
    chk("ep_id2", int'(gid0), 2);
    @(posedge clk); #1;
    cyc(2);
    r8 = 0;
    cyc(3);
    check_log("epoch", log0, '{3, 5, 1});
    // backpressure
    do_reset();
    w8 = 32'h0003_0000; r8 = 8'h10;
    cyc(2);
    ready = 0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", int'(gv0), 1);
      chk("bp_id", int'(gid0), 4);
      chk("bp_last", int'(gl0), 0);
      @(posedge clk); #1;
    end
    ready = 1;
    cyc(2);
    r8 = 0;
    cyc(3);
    check_log("bp", log0, '{8, 8, 9});
    // early release
    do_reset();
    w8 = 32'h0000_5000; r8 = 8'h08;
    cyc(2);
    r8 = 0;
    @(negedge clk);
    chk("er_last", int'(gl0), 1);
    @(posedge clk); #1;
    cyc(2);
    check_log("er", log0, '{6, 7});
    chk("er_len", log0.size(), 2);
    // weight 0 means one beat
    do_reset();
    w8 = 0; r8 = 8'h20;
    cyc(5);
    r8 = 0;
    cyc(3);
    check_log("w0", log0, '{11, 11});
    // mid-turn reset
    do_reset();
    w8 = 32'h0000_0040; r8 = 8'h02; w5 = 20'h00300; r5 = 5'h04;
    cyc(2);
    reset = 1;
    cyc(1);
    reset = 0;
    @(negedge clk);
    chk("mr_valid0", int'(gv0), 0);
    chk("mr_id0", int'(gid0), 0);
    chk("mr_onehot0", int'(goh0), 0);
    chk("mr_last0", int'(gl0), 0);
    chk("mr_stall0", int'(st0), 0);
    chk("mr_valid1", int'(gv1), 0);
    chk("mr_onehot1", int'(goh1), 0);
    @(posedge clk); #1;
    r8 = 0; r5 = 0;
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
